// File: rtl/time_msr_timer.sv
// Programmable time base / stopwatch: prescaler plus tick counter with run control,
// lap capture, compare alarm (free-run or one-shot) and sticky overflow.
module time_msr_timer #(
  parameter int unsigned CLK_PER_TICK = 5000,
  parameter int unsigned PRE_W        = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             lap,
  input  logic             one_shot,
  input  logic [CNT_W-1:0] cmp_val,
  output logic             running,
  output logic             tick,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] lap_val,
  output logic             lap_valid,
  output logic             alarm,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_TICK - 1);

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lap_val_q, lap_val_d;
  logic             ovf_q, ovf_d;
  logic             lap_valid_q, lap_valid_d;
  logic             alarm_q, alarm_d;
  logic             pre_tc;
  logic [CNT_W-1:0] cnt_inc;
  logic             advance;

  assign pre_tc  = (pre_q == PRE_LAST);
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign advance = (state_q == RUN) && !stop && !clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pre_q       <= '0;
      cnt_q       <= '0;
      lap_val_q   <= '0;
      ovf_q       <= 1'b0;
      lap_valid_q <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      lap_val_q   <= lap_val_d;
      ovf_q       <= ovf_d;
      lap_valid_q <= lap_valid_d;
      alarm_q     <= alarm_d;
    end
  end

  // Control precedence: clear > stop > start; DONE ignores start/stop.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (start && !stop) state_d = RUN;
        RUN: begin
          if (stop) state_d = IDLE;
          else if (pre_tc && one_shot && (cnt_inc == cmp_val)) state_d = DONE;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Lap samples cnt before any same-edge increment or clear.
  always_comb begin
    pre_d       = pre_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    alarm_d     = 1'b0;
    lap_valid_d = lap;
    lap_val_d   = lap ? cnt_q : lap_val_q;
    if (clear) begin
      pre_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (advance) begin
      if (pre_tc) begin
        pre_d   = '0;
        cnt_d   = cnt_inc;
        ovf_d   = ovf_q | (&cnt_q);
        alarm_d = (cnt_inc == cmp_val);
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  always_comb begin
    running   = (state_q == RUN);
    done      = (state_q == DONE);
    tick      = (state_q == RUN) && pre_tc;
    cnt       = cnt_q;
    lap_val   = lap_val_q;
    lap_valid = lap_valid_q;
    alarm     = alarm_q;
    ovf       = ovf_q;
  end

endmodule

// File: doc/time_msr_timer.md
Name: time_msr_timer

Overview:
- Parametrised successor to the fixed 5000-clock ms measurement counter.
- Combines a programmable prescaler with a tick counter of configurable width and start/stop/clear run control.
- Adds lap capture, compare alarm with free-run or one-shot mode, and a sticky overflow flag.
- Sits beside the timing blocks as the general time base/stopwatch for downstream measurement logic.

Parameters:
- CLK_PER_TICK, 5000: clocks per tick; tick period is exactly CLK_PER_TICK cycles (legal range 2..2^PRE_W).
- PRE_W, 16: prescaler counter width.
- CNT_W, 16: tick counter, lap and compare width.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- start  in  1  level-sampled; begin/resume counting
- stop  in  1  level-sampled; pause counting
- clear  in  1  synchronous clear of counters, flags and state
- lap  in  1  capture current count
- one_shot  in  1  1 = halt at compare match; 0 = free-run
- cmp_val  in  CNT_W  compare value
- running  out  1  1 in RUN state
- tick  out  1  one-cycle pulse at prescaler terminal count
- cnt  out  CNT_W  elapsed ticks
- lap_val  out  CNT_W  last captured count
- lap_valid  out  1  one-cycle pulse after capture
- alarm  out  1  one-cycle pulse on compare match
- done  out  1  1 in DONE state
- ovf  out  1  sticky wrap flag

Behaviour:
- Reset (rst=0, async):
  - State IDLE.
  - pre, cnt, lap_val = 0.
  - running, tick, lap_valid, alarm, done, ovf = 0.
- States: IDLE, RUN, DONE. Encoding is free.
- Control precedence per cycle: clear > stop > start.
- clear (any state):
  - Next state IDLE.
  - pre, cnt, ovf = 0; lap_valid and alarm do not pulse.
  - lap_val keeps its value.
- IDLE:
  - start → RUN.
  - pre and cnt hold.
- RUN:
  - stop → IDLE (pause). pre and cnt retain value, so resume keeps the fractional tick.
  - start and stop both high → IDLE.
  - Otherwise pre increments each cycle. When pre == CLK_PER_TICK-1, pre wraps to 0 and cnt increments on the same edge.
- tick:
  - tick = (state==RUN) && (pre==CLK_PER_TICK-1); a Moore output of registers.
  - First tick comes CLK_PER_TICK cycles after entering RUN from pre=0.
  - cnt shows the new value the cycle after tick.
- Wrap-around:
  - cnt at 2^CNT_W-1 plus an increment gives 0; ovf sets on that edge.
  - ovf stays set until clear or reset.
- Compare:
  - alarm is a registered one-cycle pulse, set on the edge where cnt increments to cmp_val.
  - No alarm when cnt equals cmp_val by clear or reset; cmp_val=0 therefore matches only after a wrap.
  - cmp_val is sampled at the increment edge; changing it never fires alarm by itself.
- One-shot:
  - When one_shot=1 at the matching increment, the next state is DONE.
  - DONE holds cnt==cmp_val, keeps pre frozen at 0, and drives done=1, running=0.
  - In DONE, start and stop are ignored; only clear or reset leaves DONE.
  - In free-run (one_shot=0), counting continues past the match.
- Lap:
  - Active in any state. lap_val gets the cnt value before any same-edge increment.
  - lap_valid pulses 1 the following cycle.
  - Back-to-back laps give consecutive pulses.
  - clear and lap in the same cycle: the lap captures the pre-clear cnt.
- Reset mid-count: all state drops immediately; no pulse survives reset.
- Width rule: all cnt arithmetic is modulo 2^CNT_W. pre never exceeds CLK_PER_TICK-1.

Test Plan:
- CLK_PER_TICK=4, CNT_W=4. Apply reset, then start=1 for one cycle → tick on cycles 4, 8, 12; cnt 1, 2, 3 following each tick; running=1.
- Running with pre=2, stop for 10 cycles, then start → the next tick comes exactly 2 cycles after resume; cnt unchanged during the pause.
- Free-run from cnt=14 → cnt reaches 15, then 0; ovf=1 and stays 1 across further ticks; clear → ovf=0, cnt=0, state IDLE.
- one_shot=1, cmp_val=3, start → alarm pulses once as cnt becomes 3, done=1, running=0, cnt holds 3 for 20 cycles despite start; clear → IDLE.
- lap asserted on the same cycle as tick with cnt=5 → lap_val=5, lap_valid pulse on the next cycle, cnt=6.
- Drive rst=0 asynchronously in mid-RUN with cnt=7 → all outputs 0 immediately, without waiting for a clock edge; after release, remains IDLE until start.
